// File: rtl/icache_responder.sv
// Instruction-cache responder: word store with a fixed miss latency,
// driving the fetch data/hold/exception inputs of the integer unit.
module icache_responder #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] RESET_DATA = 32'h01000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    input  logic              fetch_flush,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       ico_data,
    output logic              ico_hold,
    output logic              ico_mexc,
    output logic              resp_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        hold_q, hold_d;
    logic        mexc_q, mexc_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic [31:0] mem_q [2**ADDR_W];

    logic [31:0]       rd_addr;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_exc;
    logic [31:0]       rd_word;
    logic              accept;
    logic              enter_resp;

    // A WAIT-state fetch reads its latched address; an accept reads the live one.
    assign rd_addr = (state_q == WAIT) ? addr_q : fetch_addr;
    assign rd_idx  = rd_addr[ADDR_W+1:2];
    assign rd_exc  = (|rd_addr[1:0]) || (|rd_addr[31:ADDR_W+2]);
    assign rd_word = (wr_en && (wr_addr == rd_idx)) ? wr_data : mem_q[rd_idx];

    assign accept = fetch_req &&
                    ((state_q == IDLE) ||
                     ((state_q == RESP) && !fetch_flush));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        hold_d     = 1'b1;
        mexc_d     = 1'b0;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        enter_resp = 1'b0;

        if (accept) begin
            addr_d = fetch_addr;
            if (LATENCY == 0) begin
                enter_resp = 1'b1;
            end else begin
                state_d = WAIT;
                cnt_d   = LAT_M1;
                hold_d  = 1'b0;
                busy_d  = 1'b1;
            end
        end else if (state_q == WAIT) begin
            if (fetch_flush) begin
                state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
                enter_resp = 1'b1;
            end else begin
                cnt_d  = cnt_q - 4'd1;
                hold_d = 1'b0;
                busy_d = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end

        if (enter_resp) begin
            state_d = RESP;
            valid_d = 1'b1;
            mexc_d  = rd_exc;
            data_d  = rd_exc ? 32'h0 : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            data_q  <= RESET_DATA;
            hold_q  <= 1'b1;
            mexc_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            mexc_q  <= mexc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign ico_data   = data_q;
    assign ico_hold   = hold_q;
    assign ico_mexc   = mexc_q;
    assign resp_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: four instances at latencies 2, 0, 4, 1,
// a response scoreboard, and cycle-exact checks of hold/busy.
module tb_icache_responder;

    localparam int NDUT = 4;

    typedef struct packed {
        logic [1:0]  dut;
        logic [31:0] data;
        logic        mexc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req   [NDUT];
    logic [31:0] addr  [NDUT];
    logic        flush [NDUT];
    logic        wen   [NDUT];
    logic [9:0]  waddr [NDUT];
    logic [31:0] wdata [NDUT];
    logic [31:0] data  [NDUT];
    logic        hold  [NDUT];
    logic        mexc  [NDUT];
    logic        rv    [NDUT];
    logic        busy  [NDUT];

    exp_t exp_q[$];
    int   compared;
    int   mismatched;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        icache_responder #(
            .ADDR_W    (10),
            .LATENCY   (g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 4 : 1),
            .RESET_DATA(32'h01000000)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .fetch_req  (req[g]),
            .fetch_addr (addr[g]),
            .fetch_flush(flush[g]),
            .wr_en      (wen[g]),
            .wr_addr    (waddr[g]),
            .wr_data    (wdata[g]),
            .ico_data   (data[g]),
            .ico_hold   (hold[g]),
            .ico_mexc   (mexc[g]),
            .resp_valid (rv[g]),
            .busy       (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int g, input logic [9:0] a, input logic [31:0] d);
        wen[g]   = 1'b1;
        waddr[g] = a;
        wdata[g] = d;
        step();
        wen[g]   = 1'b0;
    endtask

    task automatic push(input int g, input logic [31:0] d, input logic m);
        exp_t e;
        e.dut  = 2'(g);
        e.data = d;
        e.mexc = m;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every response strobe pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (rv[g] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_resp dut%0d: got data %h, none pending",
                                 g, data[g]);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("resp_src dut%0d", g), 32'(g), 32'(e.dut));
                        chk($sformatf("resp_data dut%0d", g), data[g], e.data);
                        chk($sformatf("resp_mexc dut%0d", g), 32'(mexc[g]), 32'(e.mexc));
                        chk($sformatf("resp_hold dut%0d", g), 32'(hold[g]), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        for (int g = 0; g < NDUT; g++) begin
            req[g]   = 1'b0;
            addr[g]  = 32'h0;
            flush[g] = 1'b0;
            wen[g]   = 1'b0;
            waddr[g] = 10'h0;
            wdata[g] = 32'h0;
        end
        repeat (2) step();
        rst = 1'b0;
        step();
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("rst_data%0d", g), data[g], 32'h01000000);
            chk($sformatf("rst_hold%0d", g), 32'(hold[g]), 32'd1);
            chk($sformatf("rst_mexc%0d", g), 32'(mexc[g]), 32'd0);
            chk($sformatf("rst_rv%0d", g), 32'(rv[g]), 32'd0);
            chk($sformatf("rst_busy%0d", g), 32'(busy[g]), 32'd0);
        end

        // Basic fetch, latency 2
        wr(0, 10'd4, 32'h8E00C002);
        push(0, 32'h8E00C002, 1'b0);
        req[0]  = 1'b1;
        addr[0] = 32'h10;
        step();
        req[0] = 1'b0;
        chk("basic_hold_c1", 32'(hold[0]), 32'd0);
        chk("basic_busy_c1", 32'(busy[0]), 32'd1);
        step();
        chk("basic_hold_c2", 32'(hold[0]), 32'd0);
        chk("basic_rv_c2", 32'(rv[0]), 32'd0);
        step();
        chk("basic_rv_c3", 32'(rv[0]), 32'd1);
        chk("basic_busy_c3", 32'(busy[0]), 32'd0);
        step();
        chk("basic_rv_after", 32'(rv[0]), 32'd0);
        chk("basic_data_held", data[0], 32'h8E00C002);

        // Exceptions: misaligned, out of range
        push(0, 32'h0, 1'b1);
        req[0]  = 1'b1;
        addr[0] = 32'h12;
        step();
        req[0] = 1'b0;
        repeat (3) step();
        chk("exc_mexc_cleared", 32'(mexc[0]), 32'd0);
        push(0, 32'h0, 1'b1);
        req[0]  = 1'b1;
        addr[0] = 32'h1000;
        step();
        req[0] = 1'b0;
        repeat (3) step();
        chk("exc_data_held", data[0], 32'h0);

        // Back-to-back, latency 0
        wr(1, 10'd0, 32'hA);
        wr(1, 10'd1, 32'hB);
        push(1, 32'hA, 1'b0);
        push(1, 32'hB, 1'b0);
        req[1]  = 1'b1;
        addr[1] = 32'h0;
        step();
        chk("b2b_rv1", 32'(rv[1]), 32'd1);
        chk("b2b_hold1", 32'(hold[1]), 32'd1);
        addr[1] = 32'h4;
        step();
        chk("b2b_rv2", 32'(rv[1]), 32'd1);
        chk("b2b_hold2", 32'(hold[1]), 32'd1);
        chk("b2b_data2", data[1], 32'hB);
        req[1] = 1'b0;
        step();
        chk("b2b_rv_end", 32'(rv[1]), 32'd0);
        chk("b2b_hold_end", 32'(hold[1]), 32'd1);

        // Flush mid-stall, latency 4
        req[2]  = 1'b1;
        addr[2] = 32'h10;
        step();
        req[2] = 1'b0;
        chk("flush_busy_c1", 32'(busy[2]), 32'd1);
        step();
        chk("flush_hold_c2", 32'(hold[2]), 32'd0);
        flush[2] = 1'b1;
        step();
        flush[2] = 1'b0;
        chk("flush_hold", 32'(hold[2]), 32'd1);
        chk("flush_busy", 32'(busy[2]), 32'd0);
        chk("flush_data", data[2], 32'h01000000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("flush_norv%0d", i), 32'(rv[2]), 32'd0);
        end

        // Write forwarding, latency 1
        wr(3, 10'd3, 32'h1111);
        push(3, 32'h2222, 1'b0);
        req[3]  = 1'b1;
        addr[3] = 32'hC;
        step();
        req[3] = 1'b0;
        chk("fwd_hold_c1", 32'(hold[3]), 32'd0);
        wen[3]   = 1'b1;
        waddr[3] = 10'd3;
        wdata[3] = 32'h2222;
        step();
        wen[3] = 1'b0;
        chk("fwd_rv", 32'(rv[3]), 32'd1);
        step();
        push(3, 32'h2222, 1'b0);
        req[3] = 1'b1;
        step();
        req[3] = 1'b0;
        repeat (2) step();

        // Reset while stalled discards the fetch
        req[0]  = 1'b1;
        addr[0] = 32'h10;
        step();
        req[0] = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        chk("rstwait_busy", 32'(busy[0]), 32'd0);
        chk("rstwait_hold", 32'(hold[0]), 32'd1);
        chk("rstwait_data", data[0], 32'h01000000);
        repeat (4) step();

        chk("pending_at_end", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Behavioural instruction-cache responder that drives the core's instruction-fetch inputs: data word, hold (stall) and memory exception.
- Sits between the integer unit's fetch request and a word-addressed instruction store.
- The store is preloaded through a write port by the bench or loader.
- Models a configurable miss latency using the same hold convention the core expects: hold=1 means no stall, hold=0 means stall.

Parameters:
- ADDR_W, 10, word-index width; store depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, stall cycles per fetch (0..15); 0 gives a single-cycle response.
- RESET_DATA, 32'h01000000, value of ico_data after reset (SPARC NOP).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_req  in  1  core requests an instruction at fetch_addr
- fetch_addr  in  32  byte address of the fetch
- fetch_flush  in  1  abort the outstanding fetch (pipeline flush)
- wr_en  in  1  store write enable
- wr_addr  in  ADDR_W  word index to write
- wr_data  in  32  instruction word to write
- ico_data  out  32  fetched instruction
- ico_hold  out  1  1 = no stall / data valid in RESP; 0 = stall
- ico_mexc  out  1  memory exception for the current response
- resp_valid  out  1  single-cycle strobe marking a response cycle
- busy  out  1  a fetch is outstanding (WAIT state)

Behaviour:
- Reset values: on rst=1 at a clk edge the outputs take these values.
  - ico_data=RESET_DATA, ico_hold=1, ico_mexc=0, resp_valid=0, busy=0, state=IDLE, latency counter=0.
  - Store contents are not reset.
  - rst overrides every other input.
- States: IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - fetch_req=1 latches fetch_addr.
  - LATENCY=0: go to RESP.
  - LATENCY>0: go to WAIT with cnt=LATENCY-1; ico_hold=0, busy=1.
- WAIT:
  - ico_hold=0, busy=1, resp_valid=0; cnt decrements each cycle.
  - When cnt=0, go to RESP.
  - fetch_req is ignored while in WAIT.
- RESP:
  - Exactly one cycle: ico_hold=1, resp_valid=1, busy=0.
  - ico_data and ico_mexc are valid.
  - If fetch_req=1 in the same cycle, the new request is accepted (back-to-back), with the same transition rules as IDLE. Otherwise go to IDLE.
- Latency: a request accepted at edge t gives resp_valid at edge t+LATENCY+1; hold is low for exactly LATENCY cycles.
- Address decode: index = fetch_addr[ADDR_W+1:2].
- Exception: if fetch_addr[1:0]!=0, or fetch_addr[31:ADDR_W+2]!=0, the response has ico_mexc=1 and ico_data=0. The store is not read.
- Outside RESP: ico_data holds its last response value and ico_mexc=0.
- Read timing: the store is read on the cycle entering RESP.
  - A write to the same index on that cycle is forwarded (write-first): the new wr_data is returned.
  - Earlier writes are always visible.
- Flush: fetch_flush=1 in WAIT drops to IDLE next cycle with ico_hold=1, busy=0, no resp_valid, ico_data unchanged.
  - Flush in IDLE has no effect.
  - Flush in RESP suppresses acceptance of a simultaneous fetch_req.
- Writes are accepted in every state, including during a stall, and never stall.
- Reset mid-WAIT: the fetch is discarded and there is no response after reset.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> ico_data=32'h01000000, ico_hold=1, ico_mexc=0, resp_valid=0, busy=0.
- Basic fetch, LATENCY=2: write idx 4 = 32'h8E00C002; fetch_req with addr 32'h10 at edge t -> ico_hold=0 at t+1 and t+2; at t+3 resp_valid=1, ico_hold=1, ico_data=32'h8E00C002.
- Back-to-back, LATENCY=0: idx 0=32'hA, idx 1=32'hB; fetch_req held high with addr 0 then 4 -> resp_valid on two consecutive cycles with data 32'hA then 32'hB; ico_hold never drops.
- Exceptions: fetch addr 32'h12 (misaligned) and, with ADDR_W=10, addr 32'h1000 (out of range) -> each response has ico_mexc=1, ico_data=0.
- Flush mid-stall, LATENCY=4: fetch at t, fetch_flush=1 at t+2 -> IDLE at t+3, ico_hold=1, busy=0, no resp_valid at t+5.
- Write forwarding, LATENCY=1: idx 3=32'h1111; fetch addr 32'hC at t; write idx 3=32'h2222 on the cycle entering RESP -> response data=32'h2222.
